// File: rtl/apb_gpio_bank.sv
// APB GPIO bank: direction/output/input registers plus an edge-triggered
// interrupt status register with per-bit edge select and interrupt enable.
// Pins are brought in through a two-flop synchronizer. Edge events are
// masked for a short warm-up period after reset release.
module apb_gpio_bank #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 3
) (
   input  logic                  pclk,
   input  logic                  presetn,
   input  logic                  psel,
   input  logic                  penable,
   input  logic                  pwrite,
   input  logic [ADDR_WIDTH-1:0] paddr,
   input  logic [DATA_WIDTH-1:0] pwdata,
   output logic [DATA_WIDTH-1:0] prdata,
   output logic                  pready,
   output logic                  pslverr,
   input  logic [DATA_WIDTH-1:0] gpio_in,
   output logic [DATA_WIDTH-1:0] gpio_out,
   output logic [DATA_WIDTH-1:0] gpio_oe,
   output logic                  irq
);

   localparam logic [ADDR_WIDTH-1:0] A_DIR  = ADDR_WIDTH'(0);
   localparam logic [ADDR_WIDTH-1:0] A_OUT  = ADDR_WIDTH'(1);
   localparam logic [ADDR_WIDTH-1:0] A_IN   = ADDR_WIDTH'(2);
   localparam logic [ADDR_WIDTH-1:0] A_IE   = ADDR_WIDTH'(3);
   localparam logic [ADDR_WIDTH-1:0] A_EDGE = ADDR_WIDTH'(4);
   localparam logic [ADDR_WIDTH-1:0] A_ISR  = ADDR_WIDTH'(5);

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   dir_q, out_q, ie_q, edge_q, isr_q;
   logic [DATA_WIDTH-1:0]   sync_p0, sync_p1, sync_p2;
   logic [1:0]              warm_q;
   logic                    warm_done;
   logic                    wr_commit;
   logic                    addr_err;
   logic [DATA_WIDTH-1:0]   rd_mux;
   logic [DATA_WIDTH-1:0]   w1c_mask;
   logic [DATA_WIDTH-1:0]   evt;

   // APB state register
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) state_q <= IDLE;
      else          state_q <= state_d;
   end

   // Next state: any select enters ACCESS, ACCESS always lasts one cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (psel) state_d = ACCESS;
         ACCESS:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign pready    = (state_q == ACCESS);
   assign wr_commit = psel & penable & pready & pwrite;

   // Read mux and reserved-address decode
   always_comb begin
      rd_mux   = '0;
      addr_err = 1'b0;
      case (paddr)
         A_DIR:   rd_mux = dir_q;
         A_OUT:   rd_mux = out_q;
         A_IN:    rd_mux = sync_p1;
         A_IE:    rd_mux = ie_q;
         A_EDGE:  rd_mux = edge_q;
         A_ISR:   rd_mux = isr_q;
         default: addr_err = 1'b1;
      endcase
   end

   assign prdata  = pready ? rd_mux : '0;
   assign pslverr = pready & addr_err;

   // Plain read/write configuration registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         dir_q  <= '0;
         out_q  <= '0;
         ie_q   <= '0;
         edge_q <= '1;
      end else if (wr_commit) begin
         case (paddr)
            A_DIR:   dir_q  <= pwdata;
            A_OUT:   out_q  <= pwdata;
            A_IE:    ie_q   <= pwdata;
            A_EDGE:  edge_q <= pwdata;
            default: ;
         endcase
      end
   end

   // Pin synchronizer; sync_p2 holds the previous synchronized value
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         sync_p0 <= '0;
         sync_p1 <= '0;
         sync_p2 <= '0;
      end else begin
         sync_p0 <= gpio_in;
         sync_p1 <= sync_p0;
         sync_p2 <= sync_p1;
      end
   end

   // Warm-up counter: the synchronizer fills with real pin values before events count
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn)            warm_q <= 2'd0;
      else if (warm_q != 2'd3) warm_q <= warm_q + 2'd1;
   end

   assign warm_done = (warm_q == 2'd3);
   assign evt       = warm_done ? ((sync_p1 & ~sync_p2 & edge_q) |
                                   (~sync_p1 & sync_p2 & ~edge_q)) : '0;
   assign w1c_mask  = (wr_commit && (paddr == A_ISR)) ? pwdata : '0;

   // Interrupt status: a new event wins over a simultaneous clear
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) isr_q <= '0;
      else          isr_q <= (isr_q & ~w1c_mask) | evt;
   end

   assign gpio_out = out_q;
   assign gpio_oe  = dir_q;
   assign irq      = |(isr_q & ie_q);

endmodule

// File: tb/tb_apb_gpio_bank.sv
// Bench for apb_gpio_bank: APB transfers and pin changes are driven from a
// sequencer; expected transfer responses go into a queue that a monitor
// drains whenever the DUT completes a transfer.
module tb_apb_gpio_bank;

   logic       pclk = 1'b0;
   logic       presetn;
   logic       psel, penable, pwrite;
   logic [2:0] paddr;
   logic [7:0] pwdata;
   logic [7:0] prdata;
   logic       pready, pslverr;
   logic [7:0] gpio_in;
   logic [7:0] gpio_out, gpio_oe;
   logic       irq;

   int checks = 0;
   int errors = 0;

   // behavioural register image
   logic [7:0] m_dir, m_out, m_ie, m_edge, m_isr, m_pin;

   typedef struct {
      bit         is_rd;
      logic [2:0] addr;
      logic [7:0] data;
      bit         err;
   } exp_t;

   exp_t sbq[$];
   exp_t mon_e;

   apb_gpio_bank #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
      .pclk(pclk), .presetn(presetn), .psel(psel), .penable(penable),
      .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
      .pready(pready), .pslverr(pslverr), .gpio_in(gpio_in),
      .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
   );

   always #5 pclk = ~pclk;

   initial begin
      #2000000;
      $display("FAIL watchdog act=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [7:0] model_read(input logic [2:0] a);
      case (a)
         3'd0:    return m_dir;
         3'd1:    return m_out;
         3'd2:    return m_pin;
         3'd3:    return m_ie;
         3'd4:    return m_edge;
         3'd5:    return m_isr;
         default: return 8'h00;
      endcase
   endfunction

   task automatic model_write(input logic [2:0] a, input logic [7:0] d);
      case (a)
         3'd0:    m_dir  = d;
         3'd1:    m_out  = d;
         3'd3:    m_ie   = d;
         3'd4:    m_edge = d;
         3'd5:    m_isr  = m_isr & ~d;
         default: ;
      endcase
   endtask

   task automatic model_reset();
      m_dir = 8'h00; m_out = 8'h00; m_ie = 8'h00; m_edge = 8'hFF; m_isr = 8'h00;
   endtask

   // one APB transfer; no_setup raises penable together with psel
   task automatic apb_xfer(input bit wr, input logic [2:0] a, input logic [7:0] d, input bit no_setup);
      exp_t e;
      int   n;
      e.is_rd = !wr;
      e.addr  = a;
      e.err   = (a > 3'd5);
      e.data  = wr ? 8'h00 : model_read(a);
      sbq.push_back(e);
      @(posedge pclk); #1;
      psel = 1'b1; pwrite = wr; paddr = a; pwdata = d; penable = no_setup;
      if (!no_setup) begin
         @(posedge pclk); #1;
         penable = 1'b1;
      end
      n = 0;
      @(negedge pclk);
      while (!pready && n < 8) begin
         n++;
         @(negedge pclk);
      end
      chk($sformatf("wait_states a%0d", a), n, no_setup ? 1 : 0);
      @(posedge pclk); #1;
      psel = 1'b0; penable = 1'b0;
      if (wr) model_write(a, d);
   endtask

   // change pins, let them propagate, then account for the edges they made
   task automatic settle(input logic [7:0] np);
      logic [7:0] rise, fall;
      @(posedge pclk); #1;
      gpio_in = np;
      repeat (4) @(posedge pclk);
      #1;
      rise  = np & ~m_pin;
      fall  = ~np & m_pin;
      m_isr = m_isr | (rise & m_edge) | (fall & ~m_edge);
      m_pin = np;
      chk("irq_after_pins", irq, |(m_isr & m_ie));
   endtask

   // monitor: every completed transfer is matched against the queue head
   always @(negedge pclk) begin
      if (presetn && psel && penable && pready) begin
         if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected act=transfer a%0d exp=none", paddr);
         end else begin
            mon_e = sbq.pop_front();
            chk($sformatf("pslverr a%0d", mon_e.addr), pslverr, mon_e.err);
            if (mon_e.is_rd)
               chk($sformatf("prdata a%0d", mon_e.addr), prdata, mon_e.data);
         end
      end
   end

   initial begin
      presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = 3'd0; pwdata = 8'h00; gpio_in = 8'hFF;
      m_pin = 8'hFF;
      model_reset();

      // reset state
      repeat (3) @(posedge pclk);
      #1;
      chk("rst_pready", pready, 1'b0);
      chk("rst_pslverr", pslverr, 1'b0);
      chk("rst_prdata", prdata, 8'h00);
      chk("rst_gpio_out", gpio_out, 8'h00);
      chk("rst_gpio_oe", gpio_oe, 8'h00);
      chk("rst_irq", irq, 1'b0);
      @(negedge pclk);
      presetn = 1'b1;
      repeat (6) @(posedge pclk);
      #1;
      chk("idle_pready", pready, 1'b0);

      // pins held high through reset release: warm-up masks the edge
      apb_xfer(1'b0, 3'd5, 8'h00, 1'b0);
      apb_xfer(1'b0, 3'd2, 8'h00, 1'b0);
      apb_xfer(1'b0, 3'd4, 8'h00, 1'b0);
      settle(8'h00);

      // OUT write and reserved accesses
      apb_xfer(1'b1, 3'd1, 8'hA5, 1'b0);
      chk("gpio_out_a5", gpio_out, 8'hA5);
      apb_xfer(1'b0, 3'd6, 8'h00, 1'b0);
      apb_xfer(1'b1, 3'd7, 8'h3C, 1'b0);
      apb_xfer(1'b1, 3'd2, 8'h77, 1'b1);
      apb_xfer(1'b0, 3'd1, 8'h00, 1'b0);

      // rising edge on bit 0 raises irq exactly three edges after the pin change
      apb_xfer(1'b1, 3'd3, 8'h01, 1'b0);
      apb_xfer(1'b1, 3'd4, 8'h01, 1'b0);
      chk("irq_before_edge", irq, 1'b0);
      @(posedge pclk); #1;
      gpio_in = 8'h01;
      @(posedge pclk); #1;
      chk("irq_edge1", irq, 1'b0);
      @(posedge pclk); #1;
      chk("irq_edge2", irq, 1'b0);
      @(posedge pclk); #1;
      chk("irq_edge3", irq, 1'b1);
      m_pin = 8'h01;
      m_isr = m_isr | 8'h01;
      apb_xfer(1'b0, 3'd5, 8'h00, 1'b0);
      apb_xfer(1'b1, 3'd5, 8'h01, 1'b0);
      chk("irq_after_w1c", irq, 1'b0);

      // input sampled regardless of direction
      apb_xfer(1'b1, 3'd0, 8'hFF, 1'b0);
      chk("gpio_oe_ff", gpio_oe, 8'hFF);
      settle(8'h00);
      apb_xfer(1'b0, 3'd2, 8'h00, 1'b0);
      settle(8'h5A);
      apb_xfer(1'b0, 3'd2, 8'h00, 1'b0);

      // clear of bit 0 collides with a fresh rising edge on bit 0
      settle(8'h5B);
      settle(8'h5A);
      chk("irq_pre_collide", irq, 1'b1);
      @(posedge pclk); #1;
      gpio_in = 8'h5B;
      apb_xfer(1'b1, 3'd5, 8'h01, 1'b0);
      m_pin = 8'h5B;
      m_isr = m_isr | 8'h01;
      chk("irq_collide", irq, 1'b1);
      apb_xfer(1'b0, 3'd5, 8'h00, 1'b0);
      apb_xfer(1'b1, 3'd5, 8'h01, 1'b0);
      chk("irq_clear2", irq, |(m_isr & m_ie));

      // randomized traffic
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0)
            settle(8'($urandom));
         else
            apb_xfer(1'($urandom), 3'($urandom_range(0, 7)), 8'($urandom),
                     ($urandom_range(0, 3) == 0));
         chk("rnd_gpio_out", gpio_out, m_out);
         chk("rnd_gpio_oe", gpio_oe, m_dir);
         chk("rnd_irq", irq, |(m_isr & m_ie));
      end

      // reset pulse in the middle of a DIR write abandons it
      apb_xfer(1'b1, 3'd0, 8'h0F, 1'b0);
      chk("gpio_oe_0f", gpio_oe, 8'h0F);
      @(posedge pclk); #1;
      psel = 1'b1; pwrite = 1'b1; paddr = 3'd0; pwdata = 8'h3C; penable = 1'b0;
      @(posedge pclk); #1;
      penable = 1'b1;
      #1;
      presetn = 1'b0;
      #1;
      chk("rstpulse_pready", pready, 1'b0);
      chk("rstpulse_gpio_oe", gpio_oe, 8'h00);
      chk("rstpulse_irq", irq, 1'b0);
      psel = 1'b0; penable = 1'b0;
      #1;
      presetn = 1'b1;
      model_reset();
      repeat (6) @(posedge pclk);
      #1;
      chk("post_rst_gpio_oe", gpio_oe, 8'h00);
      chk("post_rst_pready", pready, 1'b0);
      apb_xfer(1'b0, 3'd0, 8'h00, 1'b0);
      apb_xfer(1'b0, 3'd4, 8'h00, 1'b0);
      apb_xfer(1'b0, 3'd5, 8'h00, 1'b0);
      apb_xfer(1'b0, 3'd2, 8'h00, 1'b0);

      repeat (4) @(posedge pclk);
      #1;
      chk("sb_drained", sbq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/apb_gpio_bank.md
APB_GPIO_BANK -- requirements
Module: apb_gpio_bank

Interface
REQ-001 Parameter DATA_WIDTH, default 8: APB data width and GPIO pin count.
REQ-002 Parameter ADDR_WIDTH, default 3: APB register address width.
REQ-003 pclk  input  1  sole clock; all state on rising edge.
REQ-004 presetn  input  1  reset, asynchronous assert, active-low.
REQ-005 psel  input  1  APB select for this bank (one bit of the upstream bank-select bus).
REQ-006 penable  input  1  APB access-phase strobe.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  ADDR_WIDTH  register address.
REQ-009 pwdata  input  DATA_WIDTH  write data.
REQ-010 prdata  output  DATA_WIDTH  read data; valid only while pready=1, otherwise 0.
REQ-011 pready  output  1  transfer-complete, registered.
REQ-012 pslverr  output  1  error response, valid only with pready=1.
REQ-013 gpio_in  input  DATA_WIDTH  asynchronous pin inputs.
REQ-014 gpio_out  output  DATA_WIDTH  pin output values = OUT register.
REQ-015 gpio_oe  output  DATA_WIDTH  pin output enables = DIR register (1 = drive).
REQ-016 irq  output  1  level interrupt = OR of (ISR AND IE).

Function
REQ-017 Register map: 0 DIR RW; 1 OUT RW; 2 IN RO; 3 IE RW; 4 EDGE RW (bit 1 = rising, 0 = falling); 5 ISR RW1C; 6-7 reserved.
REQ-018 APB FSM states IDLE, ACCESS; pready=1 exactly when state=ACCESS.
REQ-019 IDLE -> ACCESS when psel=1 (with penable 0 or 1); otherwise stay IDLE.
REQ-020 ACCESS -> IDLE unconditionally after one cycle; hence zero wait states after a proper setup phase, one wait state if penable arrives without a setup cycle.
REQ-021 Transfer commits on the edge where psel & penable & pready = 1; psel dropping while in ACCESS aborts with no register update.
REQ-022 Write to 0,1,3,4 loads pwdata; write to 2 ignored, pslverr=0; write to 5 clears ISR bits where pwdata=1.
REQ-023 Any access to 6 or 7: pslverr=1, prdata=0, no state change.
REQ-024 Read returns register contents; IN reads synchronized value; reading ISR does not clear it.
REQ-025 gpio_in passes through two synchronizer flops; a third flop holds the previous synchronized value.
REQ-026 Per-bit event = rising (sync & ~prev) when EDGE=1, falling (~sync & prev) when EDGE=0; event sets ISR bit regardless of IE.
REQ-027 Event and W1C on the same bit in the same cycle: set wins, bit stays 1.
REQ-028 Writing EDGE or IE alone never creates an event; writing IE=1 over an already set ISR bit asserts irq next cycle.
REQ-029 Event detection masked by a 2-bit warm-up counter for the first 3 pclk edges after reset release; no ISR set during warm-up.
REQ-030 DIR does not affect input sampling; IN reflects the pin even when driven as output.
REQ-031 irq is combinational from ISR and IE registers, no additional latency.

Reset
REQ-032 presetn=0 asynchronously forces: FSM IDLE, pready=0, pslverr=0, prdata=0, DIR=0x00, OUT=0x00, IE=0x00, EDGE=0xFF, ISR=0x00, synchronizer/prev flops=0, warm-up counter=0, irq=0.
REQ-033 Reset during ACCESS abandons the transfer; no register updated by it.

Verification
REQ-034 Setup psel=1,pwrite=1,paddr=1,pwdata=0xA5 then penable=1 -> pready=1 in that cycle, gpio_out=0xA5 next cycle, pslverr=0.
REQ-035 Read paddr=6 -> pready=1, pslverr=1, prdata=0x00, all registers unchanged.
REQ-036 After warm-up, IE=0x01, EDGE=0x01, gpio_in[0] 0->1 -> ISR=0x01 and irq=1 three edges after pin change; W1C write 0x01 to addr 5 -> irq=0.
REQ-037 W1C of ISR bit 0 in the same cycle a new rising event on bit 0 -> ISR[0] stays 1, irq stays 1.
REQ-038 gpio_in=0xFF held through reset release -> ISR remains 0x00 (warm-up mask); IN reads 0xFF.
REQ-039 presetn pulsed low during ACCESS of write 0x3C to DIR -> gpio_oe=0x00, pready=0, FSM IDLE.
